// File: rtl/dnu_f0_hard_pack_pkg.sv
// dnu_f0_hard_pack_pkg: widths, LUT geometry and helpers
// shared by the decision-node hard-pack stage.
package dnu_f0_hard_pack_pkg;

  localparam int QUAN_SIZE       = 4;
  localparam int MULTI_FRAME_NUM = 2;
  localparam int DEC_WORD        = 16;
  localparam int LUT_WR_WIDTH    = 8;

  localparam int LUT_DEPTH   = 1 << (2 * QUAN_SIZE);
  localparam int LUT_ENTRIES = MULTI_FRAME_NUM * LUT_DEPTH;
  localparam int LUT_AW      = $clog2(LUT_ENTRIES);
  localparam int LUT_BW      = $clog2(LUT_WR_WIDTH);
  localparam int CNT_W       = $clog2(DEC_WORD + 1);

  function automatic int lut_waddr_w(
    input int mf,
    input int depth,
    input int ww
  );
    return $clog2(mf * depth / ww);
  endfunction

  localparam int LUT_WADDR_W =
    lut_waddr_w(MULTI_FRAME_NUM, LUT_DEPTH, LUT_WR_WIDTH);

  typedef logic frame_t;

  function automatic logic [15:0] sat_add(
    input logic [15:0] c,
    input logic        a,
    input logic        b
  );
    logic [16:0] s;
    s = {1'b0, c} + 17'(a) + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/dnu_f0_hard_pack_packer.sv
// dnu_hard_packer: packs two hard bits per append into a
// DEC_WORD-bit word for one frame; reports full/partial emits.
module dnu_hard_packer
  import dnu_f0_hard_pack_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                app_i,
  input  logic [1:0]          bits_i,
  input  logic                flush_i,
  output logic                full_o,
  output logic                part_o,
  output logic [DEC_WORD-1:0] word_o
);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEC_WORD-1:0] data_q, data_d;

  // Append first, so a coinciding flush sees the new bits.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (app_i) begin
      data_d = data_q | (DEC_WORD'(bits_i) << cnt_q);
      cnt_d  = cnt_q + CNT_W'(2);
    end
    full_o = app_i && (cnt_d == CNT_W'(DEC_WORD));
    part_o = flush_i && !full_o && (cnt_d != '0);
    word_o = data_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (full_o || part_o) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/dnu_f0_hard_pack.sv
// dnu_f0_hard_pack: two-lane decision LUT + per-frame packing.
// Define DNU_DEC_STAT_EN to add per-frame ones counters.
module dnu_f0_hard_pack
  import dnu_f0_hard_pack_pkg::*;
(
  input  logic                   read_clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic                   read_addr_offset,
  input  logic [QUAN_SIZE-1:0]   vnu0_dn_in,
  input  logic [QUAN_SIZE-1:0]   vnu0_E_reg2,
  input  logic                   vnu0_tranEn_in,
  input  logic [QUAN_SIZE-1:0]   vnu1_dn_in,
  input  logic [QUAN_SIZE-1:0]   vnu1_E_reg2,
  input  logic                   vnu1_tranEn_in,
  input  logic                   flush,
  input  logic                   flush_frame,
  input  logic                   lut_we,
  input  logic [LUT_WADDR_W-1:0] lut_waddr,
  input  logic [LUT_WR_WIDTH-1:0] lut_wdata,
`ifdef DNU_DEC_STAT_EN
  input  logic                   stat_clr,
  output logic [15:0]            ones_cnt0,
  output logic [15:0]            ones_cnt1,
`endif
  output logic                   vnu0_hard,
  output logic                   vnu1_hard,
  output logic                   hard_valid,
  output logic                   read_addr_offset_out,
  output logic [DEC_WORD-1:0]    dec_word,
  output logic                   dec_word_valid,
  output logic                   dec_word_frame
);

  localparam int QW = 2 * QUAN_SIZE;

  logic lut_q [LUT_ENTRIES];

  logic                 v0_q, tr0_q, tr1_q;
  frame_t               fr_q, hfr_q, pfr_q, ffr;
  logic [QUAN_SIZE-1:0] dn0_q, e0_q, dn1_q, e1_q;
  logic                 hv_q, h0_q, h1_q;
  logic [LUT_AW-1:0]    a0, a1;

  logic                full0, full1, part0, part1;
  logic [DEC_WORD-1:0] word0, word1;
  logic                freq, blk, fl0, fl1, pend_q;
  logic [DEC_WORD-1:0] dw_q;
  logic                dwv_q;
  frame_t              dwf_q;

  // Unreset storage; must be loaded before use.
  always_ff @(posedge read_clk) begin
    if (lut_we) begin
      for (int i = 0; i < LUT_WR_WIDTH; i++) begin
        lut_q[{lut_waddr, i[LUT_BW-1:0]}] <= lut_wdata[i];
      end
    end
  end

  assign a0 = {fr_q, {dn0_q, e0_q} ^ {QW{tr0_q}}};
  assign a1 = {fr_q, {dn1_q, e1_q} ^ {QW{tr1_q}}};

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      v0_q  <= 1'b0;
      fr_q  <= '0;
      tr0_q <= 1'b0;
      tr1_q <= 1'b0;
      dn0_q <= '0;
      e0_q  <= '0;
      dn1_q <= '0;
      e1_q  <= '0;
      hv_q  <= 1'b0;
      hfr_q <= '0;
      h0_q  <= 1'b0;
      h1_q  <= 1'b0;
    end else begin
      v0_q <= in_valid;
      if (in_valid) begin
        fr_q  <= read_addr_offset;
        tr0_q <= vnu0_tranEn_in;
        tr1_q <= vnu1_tranEn_in;
        dn0_q <= vnu0_dn_in;
        e0_q  <= vnu0_E_reg2;
        dn1_q <= vnu1_dn_in;
        e1_q  <= vnu1_E_reg2;
      end
      hv_q <= v0_q;
      if (v0_q) begin
        h0_q  <= lut_q[a0] ^ tr0_q;
        h1_q  <= lut_q[a1] ^ tr1_q;
        hfr_q <= fr_q;
      end
    end
  end

  dnu_hard_packer u_pk0 (
    .clk_i   (read_clk),
    .rst_ni  (rstn),
    .app_i   (hv_q && !hfr_q),
    .bits_i  ({h1_q, h0_q}),
    .flush_i (fl0),
    .full_o  (full0),
    .part_o  (part0),
    .word_o  (word0)
  );

  dnu_hard_packer u_pk1 (
    .clk_i   (read_clk),
    .rst_ni  (rstn),
    .app_i   (hv_q && hfr_q),
    .bits_i  ({h1_q, h0_q}),
    .flush_i (fl1),
    .full_o  (full1),
    .part_o  (part1),
    .word_o  (word1)
  );

  // A full word of the other frame defers the flush by one slot.
  always_comb begin
    freq = pend_q | flush;
    ffr  = pend_q ? pfr_q : flush_frame;
    blk  = freq && (ffr ? full0 : full1);
    fl0  = freq && !ffr && !blk;
    fl1  = freq && ffr && !blk;
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= 1'b0;
      pfr_q  <= '0;
      dw_q   <= '0;
      dwv_q  <= 1'b0;
      dwf_q  <= '0;
    end else begin
      pend_q <= blk;
      if (blk) pfr_q <= ffr;
      dwv_q <= full0 | full1 | part0 | part1;
      unique case (1'b1)
        full0:   begin dw_q <= word0; dwf_q <= 1'b0; end
        full1:   begin dw_q <= word1; dwf_q <= 1'b1; end
        part0:   begin dw_q <= word0; dwf_q <= 1'b0; end
        part1:   begin dw_q <= word1; dwf_q <= 1'b1; end
        default: ;
      endcase
    end
  end

`ifdef DNU_DEC_STAT_EN
  logic [15:0] oc0_q, oc1_q;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      oc0_q <= '0;
      oc1_q <= '0;
    end else if (stat_clr) begin
      oc0_q <= '0;
      oc1_q <= '0;
    end else if (hv_q) begin
      if (hfr_q) oc1_q <= sat_add(oc1_q, h0_q, h1_q);
      else       oc0_q <= sat_add(oc0_q, h0_q, h1_q);
    end
  end

  assign ones_cnt0 = oc0_q;
  assign ones_cnt1 = oc1_q;
`endif

  assign vnu0_hard            = h0_q;
  assign vnu1_hard            = h1_q;
  assign hard_valid           = hv_q;
  assign read_addr_offset_out = hfr_q;
  assign dec_word             = dw_q;
  assign dec_word_valid       = dwv_q;
  assign dec_word_frame       = dwf_q;

endmodule

// File: tb/tb_dnu_f0_hard_pack.sv
// tb_dnu_f0_hard_pack: directed + random stimulus against a
// queue-based reference of the LUT decision and word packing.
module tb_dnu_f0_hard_pack;
  import dnu_f0_hard_pack_pkg::*;

  logic read_clk = 1'b0;
  logic rstn;
  logic in_valid, read_addr_offset;
  logic [3:0] d0, e0, d1, e1;
  logic t0, t1;
  logic flush, flush_frame, lut_we;
  logic [5:0] lut_waddr;
  logic [7:0] lut_wdata;
  logic vnu0_hard, vnu1_hard, hard_valid, offs_out;
  logic [15:0] dec_word;
  logic dec_word_valid, dec_word_frame;
`ifdef DNU_DEC_STAT_EN
  logic stat_clr = 1'b0;
  logic [15:0] ones_cnt0, ones_cnt1;
`endif

  dnu_f0_hard_pack dut (
    .read_clk             (read_clk),
    .rstn                 (rstn),
    .in_valid             (in_valid),
    .read_addr_offset     (read_addr_offset),
    .vnu0_dn_in           (d0),
    .vnu0_E_reg2          (e0),
    .vnu0_tranEn_in       (t0),
    .vnu1_dn_in           (d1),
    .vnu1_E_reg2          (e1),
    .vnu1_tranEn_in       (t1),
    .flush                (flush),
    .flush_frame          (flush_frame),
    .lut_we               (lut_we),
    .lut_waddr            (lut_waddr),
    .lut_wdata            (lut_wdata),
`ifdef DNU_DEC_STAT_EN
    .stat_clr             (stat_clr),
    .ones_cnt0            (ones_cnt0),
    .ones_cnt1            (ones_cnt1),
`endif
    .vnu0_hard            (vnu0_hard),
    .vnu1_hard            (vnu1_hard),
    .hard_valid           (hard_valid),
    .read_addr_offset_out (offs_out),
    .dec_word             (dec_word),
    .dec_word_valid       (dec_word_valid),
    .dec_word_frame       (dec_word_frame)
  );

  always #5 read_clk = ~read_clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: LUT array, beat stages, per-frame bit queues.
  bit lut_m [512];
  bit m_s0v, m_s0fr, m_t0, m_t1;
  bit [3:0] m_d0, m_e0, m_d1, m_e1;
  bit m_hv, m_h0, m_h1, m_hfr;
  bit [15:0] m_dw;
  bit m_dwv, m_dwf, m_pend, m_pfr;
  bit qb0 [$];
  bit qb1 [$];

  int n_strb;
  bit [15:0] last_w;
  bit last_f;
  bit fr_log [$];

  function automatic bit [15:0] pack(input bit q [$]);
    bit [15:0] w = '0;
    foreach (q[i]) w[i] = q[i];
    return w;
  endfunction

  task automatic model_reset();
    m_s0v = 0; m_s0fr = 0; m_t0 = 0; m_t1 = 0;
    m_d0 = 0; m_e0 = 0; m_d1 = 0; m_e1 = 0;
    m_hv = 0; m_h0 = 0; m_h1 = 0; m_hfr = 0;
    m_dw = 0; m_dwv = 0; m_dwf = 0;
    m_pend = 0; m_pfr = 0;
    qb0.delete();
    qb1.delete();
  endtask

  task automatic model_edge();
    bit f0 = 0, f1 = 0, nv = 0, np = 0, req, rf;
    bit [15:0] w0 = 0, w1 = 0;
    bit [8:0] a;
    if (m_hv) begin
      if (m_hfr) begin qb1.push_back(m_h0); qb1.push_back(m_h1); end
      else begin qb0.push_back(m_h0); qb0.push_back(m_h1); end
    end
    if (qb0.size() == DEC_WORD) begin
      f0 = 1; w0 = pack(qb0); qb0.delete();
    end
    if (qb1.size() == DEC_WORD) begin
      f1 = 1; w1 = pack(qb1); qb1.delete();
    end
    if (f0) begin nv = 1; m_dw = w0; m_dwf = 0; end
    else if (f1) begin nv = 1; m_dw = w1; m_dwf = 1; end
    req = m_pend || flush;
    rf = m_pend ? m_pfr : flush_frame;
    if (req) begin
      if (rf ? f0 : f1) begin
        np = 1; m_pfr = rf;
      end else if (!rf && !f0 && qb0.size() > 0) begin
        nv = 1; m_dw = pack(qb0); m_dwf = 0; qb0.delete();
      end else if (rf && !f1 && qb1.size() > 0) begin
        nv = 1; m_dw = pack(qb1); m_dwf = 1; qb1.delete();
      end
    end
    m_pend = np;
    m_dwv = nv;
    if (m_s0v) begin
      a = {m_s0fr, {m_d0, m_e0} ^ {8{m_t0}}};
      m_h0 = lut_m[a] ^ m_t0;
      a = {m_s0fr, {m_d1, m_e1} ^ {8{m_t1}}};
      m_h1 = lut_m[a] ^ m_t1;
      m_hfr = m_s0fr;
    end
    m_hv = m_s0v;
    if (lut_we)
      for (int j = 0; j < 8; j++)
        lut_m[{lut_waddr, 3'(j)}] = lut_wdata[j];
    m_s0v = in_valid;
    if (in_valid) begin
      m_s0fr = read_addr_offset;
      m_d0 = d0; m_e0 = e0; m_t0 = t0;
      m_d1 = d1; m_e1 = e1; m_t1 = t1;
    end
  endtask

  task automatic cmp_all();
    chk("hard_valid", hard_valid, m_hv);
    chk("vnu0_hard", vnu0_hard, m_h0);
    chk("vnu1_hard", vnu1_hard, m_h1);
    chk("offs_out", offs_out, m_hfr);
    chk("dec_word", dec_word, m_dw);
    chk("dw_valid", dec_word_valid, m_dwv);
    chk("dw_frame", dec_word_frame, m_dwf);
  endtask

  task automatic tick();
    model_edge();
    @(posedge read_clk);
    #1;
    cmp_all();
    if (dec_word_valid) begin
      n_strb++;
      last_w = dec_word;
      last_f = dec_word_frame;
      fr_log.push_back(dec_word_frame);
    end
    in_valid = 0;
    flush = 0;
    lut_we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(input bit fr,
                      input bit [3:0] a0, input bit [3:0] b0,
                      input bit c0,
                      input bit [3:0] a1, input bit [3:0] b1,
                      input bit c1);
    in_valid = 1;
    read_addr_offset = fr;
    d0 = a0; e0 = b0; t0 = c0;
    d1 = a1; e1 = b1; t1 = c1;
    tick();
  endtask

  task automatic do_flush(input bit fr);
    flush = 1;
    flush_frame = fr;
    tick();
  endtask

  task automatic clr_log();
    n_strb = 0;
    fr_log.delete();
  endtask

  task automatic rst_pulse();
    rstn = 0;
    #1;
    model_reset();
    cmp_all();
    @(posedge read_clk);
    #1;
    rstn = 1;
  endtask

  initial begin
    bit [5:0] wa;
    rstn = 0;
    in_valid = 0; read_addr_offset = 0;
    d0 = 0; e0 = 0; t0 = 0; d1 = 0; e1 = 0; t1 = 0;
    flush = 0; flush_frame = 0;
    lut_we = 0; lut_waddr = 0; lut_wdata = 0;
    model_reset();
    clr_log();
    #12;
    cmp_all();
    rstn = 1;

    // LUT = sign of dn_in, both frames
    for (int w = 0; w < 64; w++) begin
      wa = 6'(w);
      lut_we = 1;
      lut_waddr = wa;
      lut_wdata = wa[4] ? 8'hFF : 8'h00;
      tick();
    end

    beat(0, 4'h9, 4'h0, 0, 4'h0, 4'h0, 0);
    tick();
    chk("id_hv", hard_valid, 1);
    chk("id_h0", vnu0_hard, 1);

    beat(0, 4'h9, 4'h3, 1, 4'h0, 4'h0, 0);
    tick();
    chk("tr_h0", vnu0_hard, 1);
    lut_we = 1; lut_waddr = 6'h0D; lut_wdata = 8'h10;
    tick();
    beat(0, 4'h9, 4'h3, 1, 4'h0, 4'h0, 0);
    tick();
    chk("tr_h0_new", vnu0_hard, 0);
    idle(2);
    do_flush(0);
    idle(2);

    clr_log();
    for (int i = 0; i < 8; i++)
      beat(0, 4'(8 + i), 4'(i), 0, 4'(i), 4'(i), 0);
    idle(3);
    chk("pack_cnt", n_strb, 1);
    chk("pack_word", last_w, 16'h5555);
    chk("pack_fr", last_f, 0);

    clr_log();
    for (int i = 0; i < 16; i++)
      beat(1'(i), 4'($urandom), 4'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), 1'($urandom));
    idle(3);
    chk("il_cnt", n_strb, 2);
    chk("il_fr0", fr_log[0], 0);
    chk("il_fr1", fr_log[1], 1);

    clr_log();
    for (int i = 0; i < 3; i++)
      beat(1, 4'h8, 4'h0, 0, 4'hC, 4'h5, 0);
    idle(2);
    do_flush(1);
    idle(1);
    chk("fl_cnt", n_strb, 1);
    chk("fl_word", last_w, 16'h003F);
    chk("fl_fr", last_f, 1);
    clr_log();
    do_flush(1);
    idle(2);
    chk("fl2_cnt", n_strb, 0);

    // entry 0x10 of frame 0 is 0 before the write
    beat(0, 4'h1, 4'h0, 0, 4'h0, 4'h0, 0);
    lut_we = 1; lut_waddr = 6'h02; lut_wdata = 8'h01;
    beat(0, 4'h1, 4'h0, 0, 4'h0, 4'h0, 0);
    chk("col_old", vnu0_hard, 0);
    tick();
    chk("col_new", vnu0_hard, 1);
    idle(2);
    clr_log();
    rst_pulse();
    do_flush(0);
    do_flush(1);
    idle(2);
    chk("rst_cnt", n_strb, 0);

    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      read_addr_offset = 1'($urandom);
      d0 = 4'($urandom); e0 = 4'($urandom); t0 = 1'($urandom);
      d1 = 4'($urandom); e1 = 4'($urandom); t1 = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      flush_frame = 1'($urandom);
      lut_we = ($urandom_range(0, 9) == 0);
      lut_waddr = 6'($urandom);
      lut_wdata = 8'($urandom);
      tick();
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
